// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: pixel divider, scan counters, registered sync/visible decode
// and a once-per-frame board snapshot taken at the start of vertical blank.
// The sync, valid and pulse outputs are registered from the next counter
// values, so they line up with x_cnt/y_cnt in the same cycle.
module vga_scan_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int BOARD_SIZE = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BOARD_SIZE-1:0] board_in,
  output logic [BOARD_SIZE-1:0] board_out,
  output logic [9:0]            x_cnt,
  output logic [9:0]            y_cnt,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  valid,
  output logic                  pix_tick,
  output logic                  frame_start,
  output logic                  vblank_start
);

  // Totals must fit the 10-bit counters; CLK_DIV must be at least 1.
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick_q, tick_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  valid_q, valid_d;
  logic                  frame_q, frame_d;
  logic                  vblank_q, vblank_d;
  logic [BOARD_SIZE-1:0] board_q, board_d;

  // Next-state: divider, scan counters and decode of the next counter values.
  // tick_q is registered so it reads 0 in the cycle after reset even when
  // CLK_DIV is 1; the counters step on the edge that ends a tick cycle.
  always_comb begin
    div_d    = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    tick_d   = (div_d == DIV_MAX);
    x_d      = x_q;
    y_d      = y_q;
    if (tick_q) begin
      if (x_q == H_MAX) begin
        x_d = '0;
        y_d = (y_q == V_MAX) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hsync_d  = !((x_d >= HS_BEG) && (x_d < HS_END));
    vsync_d  = !((y_d >= VS_BEG) && (y_d < VS_END));
    valid_d  = (x_d < H_VIS) && (y_d < V_VIS);
    // Pulses only on the edge that actually enters the position.
    frame_d  = tick_q && (x_d == '0) && (y_d == '0);
    vblank_d = tick_q && (x_d == '0) && (y_d == V_VIS);
    board_d  = vblank_d ? board_in : board_q;
  end

  // State register with synchronous reset; reset-entered (0,0) issues no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      tick_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      valid_q  <= 1'b1;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
      board_q  <= '0;
    end else begin
      div_q    <= div_d;
      tick_q   <= tick_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
      vblank_q <= vblank_d;
      board_q  <= board_d;
    end
  end

  assign board_out    = board_q;
  assign x_cnt        = x_q;
  assign y_cnt        = y_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign valid        = valid_q;
  assign pix_tick     = tick_q;
  assign frame_start  = frame_q;
  assign vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl using a shrunken raster so full frames fit in a
// short run: 15 pixels/line (visible 8, hsync on x 10..12), 10 lines/frame
// (visible 6, vsync on y 7..8). One instance divides by 4, one by 1.
module tb_vga_scan_ctrl;
  localparam int BS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [BS-1:0] board_in;

  logic [BS-1:0] b4, b1;
  logic [9:0]    x4, y4, x1, y1;
  logic          hs4, vs4, va4, pt4, fs4, vb4;
  logic          hs1, vs1, va1, pt1, fs1, vb1;

  int checks   = 0;
  int failures = 0;
  int t;
  int fs4_cnt = 0, fs1_cnt = 0, vb4_cnt = 0;
  logic [BS-1:0] exp_b4, exp_b1;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .BOARD_SIZE(BS)
  ) dut (
    .clk(clk), .rst(rst), .board_in(board_in), .board_out(b4),
    .x_cnt(x4), .y_cnt(y4), .hsync(hs4), .vsync(vs4), .valid(va4),
    .pix_tick(pt4), .frame_start(fs4), .vblank_start(vb4)
  );

  vga_scan_ctrl #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .BOARD_SIZE(BS)
  ) dut1 (
    .clk(clk), .rst(rst), .board_in(board_in), .board_out(b1),
    .x_cnt(x1), .y_cnt(y1), .hsync(hs1), .vsync(vs1), .valid(va1),
    .pix_tick(pt1), .frame_start(fs1), .vblank_start(vb1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Expected outputs at cycle t after reset release; edge_board is the
  // board_in value present at the edge that opened cycle t.
  task automatic check_cycle(input logic [BS-1:0] edge_board);
    int p, ex, ey;
    bit ent;
    // divide-by-4 instance: pixel p spans cycles 4p..4p+3, tick on the last
    p   = t / 4;
    ex  = p % 15;
    ey  = (p / 15) % 10;
    ent = (t % 4 == 0) && (t > 0);
    if (ent && ex == 0 && ey == 6) exp_b4 = edge_board;
    chk("x4", x4, ex);
    chk("y4", y4, ey);
    chk("tick4", pt4, (t % 4 == 3));
    chk("hsync4", hs4, !(ex >= 10 && ex < 13));
    chk("vsync4", vs4, !(ey >= 7 && ey < 9));
    chk("valid4", va4, (ex < 8 && ey < 6));
    chk("fs4", fs4, (ent && ex == 0 && ey == 0));
    chk("vb4", vb4, (ent && ex == 0 && ey == 6));
    chk("board4", b4, exp_b4);
    // divide-by-1 instance: first tick in cycle 1, x steps every cycle after
    p   = (t == 0) ? 0 : t - 1;
    ex  = p % 15;
    ey  = (p / 15) % 10;
    ent = (t >= 2);
    if (ent && ex == 0 && ey == 6) exp_b1 = edge_board;
    chk("x1", x1, ex);
    chk("y1", y1, ey);
    chk("tick1", pt1, (t >= 1));
    chk("hsync1", hs1, !(ex >= 10 && ex < 13));
    chk("vsync1", vs1, !(ey >= 7 && ey < 9));
    chk("valid1", va1, (ex < 8 && ey < 6));
    chk("fs1", fs1, (ent && ex == 0 && ey == 0));
    chk("vb1", vb1, (ent && ex == 0 && ey == 6));
    chk("board1", b1, exp_b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    check_cycle(board_in);
    if (fs4) fs4_cnt++;
    if (fs1) fs1_cnt++;
    if (vb4) vb4_cnt++;
    board_in = board_in + 16'h1357;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_x4"}, x4, 0);
    chk({tag, "_y4"}, y4, 0);
    chk({tag, "_hs4"}, hs4, 1);
    chk({tag, "_vs4"}, vs4, 1);
    chk({tag, "_va4"}, va4, 1);
    chk({tag, "_pt4"}, pt4, 0);
    chk({tag, "_fs4"}, fs4, 0);
    chk({tag, "_vb4"}, vb4, 0);
    chk({tag, "_b4"}, b4, 0);
    chk({tag, "_pt1"}, pt1, 0);
    chk({tag, "_x1"}, x1, 0);
    chk({tag, "_b1"}, b1, 0);
  endtask

  initial begin
    rst      = 1'b1;
    board_in = 16'h00a5;
    exp_b4   = '0;
    exp_b1   = '0;
    t        = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;

    // two full frames of the divided instance with board_in changing each clk
    for (int i = 0; i < 1300; i++) step();
    chk("fs4_count", fs4_cnt, 2);
    chk("vb4_count", vb4_cnt, 2);
    chk("fs1_count", fs1_cnt, 8);

    // move to the cycle right after the tick into pixel (5,3), then reset
    for (int i = 0; i < 700; i++) begin
      if (((t / 4) % 150 == 50) && (t % 4 == 1)) break;
      step();
    end
    chk("pre_rst_x4", x4, 5);
    chk("pre_rst_y4", y4, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    exp_b4 = '0;
    exp_b1 = '0;
    t      = 0;
    rst    = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("x4_after_rst_4clk", x4, 1);
    for (int i = 0; i < 200; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Generates the 640x480@60 scan that drives the playing-field renderer.
- Produces the pixel counters x_cnt/y_cnt, the syncs hsync/vsync and the visible-area flag.
- Takes a tear-free snapshot of the game board once per frame, at the start of vertical blank. The renderer only ever sees a board that is stable for the whole visible frame.
- Sits between the game logic (board writer) and the renderer/VGA pins.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 1.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BACK, 33, vertical back porch (lines).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- board_in  in  `BOARD_SIZE  live board from game logic, may change any cycle.
- board_out  out  `BOARD_SIZE  frame-stable board snapshot for the renderer.
- x_cnt  out  10  current horizontal pixel index, 0..H_TOTAL-1.
- y_cnt  out  10  current line index, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- valid  out  1  high while x_cnt < H_VISIBLE and y_cnt < V_VISIBLE.
- pix_tick  out  1  one-clk pulse marking a pixel advance.
- frame_start  out  1  one-clk pulse when the counters enter (0,0).
- vblank_start  out  1  one-clk pulse when the counters enter (0,V_VISIBLE); also the snapshot cycle.

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
  - Both must fit in 10 bits.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_tick is high in the cycle where div == CLK_DIV-1.
  - CLK_DIV = 1 makes pix_tick constant high after reset.
- Counters advance only on the clk edge that follows a cycle with pix_tick high.
  - h wraps at H_TOTAL-1 to 0.
  - On an h wrap, v increments; v wraps at V_TOTAL-1 to 0.
  - h and v never take values >= their totals.
- Registered outputs:
  - hsync, vsync, valid, frame_start and vblank_start are registers.
  - They are computed from the next counter values, so they align exactly with x_cnt/y_cnt in the same cycle. There is no pipeline skew.
- Decode rules:
  - hsync = 0 iff H_VISIBLE+H_FRONT <= x_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync = 0 iff V_VISIBLE+V_FRONT <= y_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - valid is combinationally consistent with x_cnt/y_cnt as defined above.
- Pulses:
  - frame_start is high for exactly the one clk cycle in which (x_cnt,y_cnt) first equals (0,0) after a wrap.
  - vblank_start behaves the same for (0,V_VISIBLE).
  - Neither pulse persists across the remaining CLK_DIV-1 cycles of that pixel.
- Snapshot:
  - board_out <= board_in on the same edge that raises vblank_start.
  - board_out holds otherwise, including throughout the visible area.
- Reset (synchronous, wins over everything):
  - div = 0, x_cnt = 0, y_cnt = 0.
  - hsync = 1, vsync = 1, valid = 1, pix_tick = 0.
  - frame_start = 0, vblank_start = 0, board_out = 0.
  - No frame_start is issued for the reset-entered (0,0); the first frame_start follows the first full frame.
- Reset mid-line/mid-frame: the scan restarts from (0,0) on the next cycle, and the next tick occurs CLK_DIV cycles after reset deasserts.
- board_in changing in the snapshot cycle itself: the value present at that edge is captured.

Test Plan:
- Reset, then run 1 frame (800*525*4 = 1,680,000 clks):
  - pix_tick period is 4 clks.
  - x_cnt steps 0..799 and y_cnt steps 0..524, each exactly once per frame.
  - frame_start fires exactly once, at clk 1,680,000 after the first tick boundary.
- Line timing:
  - hsync low for exactly 96 pixels (384 clks), starting at x_cnt = 656.
  - valid drops at x_cnt = 640 and rises at x_cnt = 0 on visible lines.
- Frame timing:
  - vsync low only for y_cnt in {490,491}, i.e. 2*800*4 = 6400 clks.
  - valid stays 0 for all of y_cnt 480..524.
- Snapshot:
  - Toggle board_in every clk with a counter pattern.
  - board_out changes only in the vblank_start cycle (x_cnt=0,y_cnt=480) and equals board_in at that edge.
  - board_out is constant for all valid=1 cycles.
- Mid-frame reset:
  - Assert rst for 1 clk at (x=300,y=200).
  - Next cycle: x_cnt = 0, y_cnt = 0, hsync = vsync = 1, frame_start = 0.
  - x_cnt = 1 appears 4 clks later.
- CLK_DIV = 1 build:
  - pix_tick stays high after reset.
  - x_cnt increments every clk.
  - Frame length is 420,000 clks.
